// File: rtl/mem_req_scheduler.sv
// mem_req_scheduler: store buffer plus single load slot ahead of the data memory.
// Issues at most one memory operation per cycle (load or store drain) and blocks
// loads that hit a buffered store word.
// Optional build macro: STORE_FWD_EN forwards buffered sw data to a matching lw/lbu.

package mem_req_scheduler_pkg;
  localparam int unsigned ROB_TAG_BITS = 6;
  localparam int unsigned PREG_BITS    = 7;

  // LSQ entry carried for both stores and loads
  typedef struct packed {
    logic [31:0]             addr;
    logic [31:0]             ps2_data;
    logic [2:0]              func3;
    logic [ROB_TAG_BITS-1:0] rob_tag;
    logic [PREG_BITS-1:0]    pd;
    logic                    sw_sh_signal;
    logic                    store;
  } lsq_t;

  // Load result returned to the back end
  typedef struct packed {
    logic [31:0]             data;
    logic [ROB_TAG_BITS-1:0] rob_fu_mem;
    logic [PREG_BITS-1:0]    p_mem;
    logic                    fu_mem_ready;
    logic                    fu_mem_done;
  } mem_data_t;
endpackage

module mem_req_scheduler
  import mem_req_scheduler_pkg::*;
#(
  parameter int unsigned SB_DEPTH   = 4,
  parameter int unsigned WADDR_BITS = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_commit_valid,
  input  lsq_t                       st_commit_entry,
  output logic                       st_commit_ready,
  input  logic                       ld_req_valid,
  input  lsq_t                       ld_req,
  output logic                       ld_req_ready,
  input  logic                       flush,
  input  logic                       load_ready,
  output logic                       store_wb,
  output lsq_t                       lsq_in,
  output logic                       load_mem,
  output lsq_t                       lsq_load,
  output logic                       fwd_valid,
  output mem_data_t                  fwd_data,
  output logic [$clog2(SB_DEPTH):0]  sb_count,
  output logic                       sb_empty
);

  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SB_DEPTH);

  lsq_t             sb_mem [SB_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  lsq_t             slot;
  logic             slot_valid;
  logic             push;
  logic             pop;
  logic             ld_accept;
  logic             hazard;
  logic             fwd_hit;
`ifdef STORE_FWD_EN
  lsq_t             young;
  mem_data_t        fwd_next;
`endif

  assign st_commit_ready = (count != FULL_CNT);
  assign ld_req_ready    = !slot_valid;
  assign push      = st_commit_valid && st_commit_ready && st_commit_entry.store;
  assign pop       = store_wb;
  assign ld_accept = ld_req_valid && ld_req_ready && !flush && !ld_req.store;
  assign lsq_in    = store_wb ? sb_mem[head] : '0;
  assign lsq_load  = load_mem ? slot : '0;
  assign sb_count  = count;
  assign sb_empty  = (count == '0);

  // Word-address match of the slot against every occupied entry; last match is youngest
  always_comb begin
    hazard = 1'b0;
`ifdef STORE_FWD_EN
    young  = '0;
`endif
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if ((CNT_W'(i) < count) &&
          (sb_mem[head + PTR_W'(i)].addr[WADDR_BITS+1:2] == slot.addr[WADDR_BITS+1:2])) begin
        hazard = slot_valid;
`ifdef STORE_FWD_EN
        young  = sb_mem[head + PTR_W'(i)];
`endif
      end
    end
  end

  // Issue arbitration: full drain, then clean load, then any drain
  always_comb begin
    store_wb = 1'b0;
    load_mem = 1'b0;
    if (count == FULL_CNT) begin
      store_wb = 1'b1;
    end else if (slot_valid && !hazard && load_ready && !flush) begin
      load_mem = 1'b1;
    end else if (count != '0) begin
      store_wb = 1'b1;
    end
  end

`ifdef STORE_FWD_EN
  // Forward from the youngest matching sw to an lw or lbu without using memory
  always_comb begin
    fwd_hit  = hazard && !flush && !young.sw_sh_signal &&
               ((slot.func3 == 3'b010) || (slot.func3 == 3'b100));
    fwd_next = '0;
    fwd_next.rob_fu_mem   = slot.rob_tag;
    fwd_next.p_mem        = slot.pd;
    fwd_next.fu_mem_ready = 1'b1;
    fwd_next.fu_mem_done  = 1'b1;
    if (slot.func3 == 3'b100) begin
      fwd_next.data = {24'b0, young.ps2_data[{slot.addr[1:0], 3'b000} +: 8]};
    end else begin
      fwd_next.data = young.ps2_data;
    end
  end

  // One-cycle forwarded result pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_valid <= 1'b0;
      fwd_data  <= '0;
    end else begin
      fwd_valid <= fwd_hit;
      fwd_data  <= fwd_hit ? fwd_next : '0;
    end
  end
`else
  assign fwd_hit   = 1'b0;
  assign fwd_valid = 1'b0;
  assign fwd_data  = '0;
`endif

  // Store buffer pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Store buffer payload storage
  always_ff @(posedge clk) begin
    if (push) sb_mem[tail] <= st_commit_entry;
  end

  // Load slot: cleared by flush, issue or forward; filled only when empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid <= 1'b0;
      slot       <= '0;
    end else if (flush || load_mem || fwd_hit) begin
      slot_valid <= 1'b0;
    end else if (ld_accept) begin
      slot_valid <= 1'b1;
      slot       <= ld_req;
    end
  end

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed bench for mem_req_scheduler; expectations follow STORE_FWD_EN when defined.
module tb_mem_req_scheduler;
  import mem_req_scheduler_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  logic      st_commit_valid;
  lsq_t      st_commit_entry;
  logic      st_commit_ready;
  logic      ld_req_valid;
  lsq_t      ld_req;
  logic      ld_req_ready;
  logic      flush;
  logic      load_ready;
  logic      store_wb;
  lsq_t      lsq_in;
  logic      load_mem;
  lsq_t      lsq_load;
  logic      fwd_valid;
  mem_data_t fwd_data;
  logic [2:0] sb_count;
  logic      sb_empty;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  mem_req_scheduler #(.SB_DEPTH(4), .WADDR_BITS(15)) dut (
    .clk(clk), .reset(reset),
    .st_commit_valid(st_commit_valid), .st_commit_entry(st_commit_entry),
    .st_commit_ready(st_commit_ready),
    .ld_req_valid(ld_req_valid), .ld_req(ld_req), .ld_req_ready(ld_req_ready),
    .flush(flush), .load_ready(load_ready),
    .store_wb(store_wb), .lsq_in(lsq_in),
    .load_mem(load_mem), .lsq_load(lsq_load),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data),
    .sb_count(sb_count), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  function automatic lsq_t mk_st(input logic [31:0] a, input logic [31:0] d, input logic sh);
    lsq_t e;
    e = '0;
    e.addr = a;
    e.ps2_data = d;
    e.sw_sh_signal = sh;
    e.func3 = sh ? 3'b001 : 3'b010;
    e.store = 1'b1;
    return e;
  endfunction

  function automatic lsq_t mk_ld(input logic [31:0] a, input logic [2:0] f3,
                                 input int rob, input int pd);
    lsq_t e;
    e = '0;
    e.addr = a;
    e.func3 = f3;
    e.rob_tag = ROB_TAG_BITS'(rob);
    e.pd = PREG_BITS'(pd);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    st_commit_valid = 1'b0;
    st_commit_entry = '0;
    ld_req_valid    = 1'b0;
    ld_req          = '0;
    flush           = 1'b0;
    load_ready      = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic commit(input lsq_t e);
    st_commit_valid = 1'b1;
    st_commit_entry = e;
  endtask

  task automatic offer(input lsq_t e);
    ld_req_valid = 1'b1;
    ld_req = e;
  endtask

  initial begin
    lsq_t tmp;
    reset = 1'b0;
    idle();
    #3;
    check("rst_store_wb", store_wb, 0);
    check("rst_load_mem", load_mem, 0);
    check("rst_commit_ready", st_commit_ready, 1);
    check("rst_ld_ready", ld_req_ready, 1);
    check("rst_empty", sb_empty, 1);
    check("rst_count", sb_count, 0);
    check("rst_fwd_valid", fwd_valid, 0);
    @(negedge clk);
    reset = 1'b1;

    // single sw drains the next cycle
    step(); commit(mk_st(32'h100, 32'hDEADBEEF, 1'b0)); #1;
    check("s1_ready", st_commit_ready, 1);
    check("s1_no_wb_yet", store_wb, 0);
    step(); #1;
    check("s1_wb", store_wb, 1);
    check("s1_addr", lsq_in.addr, 32'h100);
    check("s1_data", lsq_in.ps2_data, 32'hDEADBEEF);
    check("s1_count", sb_count, 1);
    step(); #1;
    check("s1_empty", sb_empty, 1);
    check("s1_wb_done", store_wb, 0);

    // commit with store=0 is discarded
    step(); tmp = mk_st(32'h104, 32'h1, 1'b0); tmp.store = 1'b0; commit(tmp); #1;
    step(); #1;
    check("nost_empty", sb_empty, 1);
    check("nost_wb", store_wb, 0);

    // fill the buffer using interleaved load issues
    step(); offer(mk_ld(32'h400, 3'b010, 1, 1)); #1;
    step(); commit(mk_st(32'h500, 32'h0, 1'b0)); load_ready = 1'b1; #1;
    check("f_c1_load", load_mem, 1);
    check("f_c1_wb", store_wb, 0);
    step(); commit(mk_st(32'h504, 32'h1, 1'b0)); offer(mk_ld(32'h404, 3'b010, 2, 2)); load_ready = 1'b0; #1;
    check("f_c2_wb", store_wb, 1);
    check("f_c2_addr", lsq_in.addr, 32'h500);
    step(); commit(mk_st(32'h508, 32'h2, 1'b0)); load_ready = 1'b1; #1;
    check("f_c3_load", load_mem, 1);
    step(); commit(mk_st(32'h50C, 32'h3, 1'b0)); offer(mk_ld(32'h408, 3'b010, 3, 3)); load_ready = 1'b0; #1;
    step(); commit(mk_st(32'h510, 32'h4, 1'b0)); load_ready = 1'b1; #1;
    step(); commit(mk_st(32'h514, 32'h5, 1'b0)); offer(mk_ld(32'h40C, 3'b010, 4, 4)); load_ready = 1'b0; #1;
    step(); commit(mk_st(32'h518, 32'h6, 1'b0)); load_ready = 1'b1; #1;
    check("f_c7_load", load_mem, 1);
    check("f_c7_rob", lsq_load.rob_tag, 4);
    check("f_c7_count", sb_count, 3);
    step(); commit(mk_st(32'h51C, 32'h7, 1'b0)); offer(mk_ld(32'h410, 3'b010, 5, 5)); load_ready = 1'b0; #1;
    check("full_ready", st_commit_ready, 0);
    check("full_count", sb_count, 4);
    check("full_wb", store_wb, 1);
    check("full_addr", lsq_in.addr, 32'h50C);
    check("full_no_load", load_mem, 0);
    step(); load_ready = 1'b1; #1;
    check("after_full_count", sb_count, 3);
    check("after_full_ready", st_commit_ready, 1);
    check("after_full_load", load_mem, 1);
    check("after_full_laddr", lsq_load.addr, 32'h410);
    check("after_full_wb", store_wb, 0);
    step(); load_ready = 1'b0; #1;
    check("drain_s4", lsq_in.addr, 32'h510);
    step(); #1;
    step(); #1;
    step(); #1;
    check("fill_empty", sb_empty, 1);

    // lw hits a buffered sw
    step(); commit(mk_st(32'h200, 32'hDEADBEEF, 1'b0)); offer(mk_ld(32'h200, 3'b010, 5, 9)); #1;
    step(); #1;
    check("h_stall_load", load_mem, 0);
    check("h_drain", store_wb, 1);
    check("h_drain_addr", lsq_in.addr, 32'h200);
    check("h_fwd_early", fwd_valid, 0);
    step(); #1;
`ifdef STORE_FWD_EN
    check("h_fwd_valid", fwd_valid, 1);
    check("h_fwd_data", fwd_data.data, 32'hDEADBEEF);
    check("h_fwd_rob", fwd_data.rob_fu_mem, 5);
    check("h_fwd_pd", fwd_data.p_mem, 9);
    check("h_fwd_no_load", load_mem, 0);
`else
    check("h_load", load_mem, 1);
    check("h_load_rob", lsq_load.rob_tag, 5);
    check("h_fwd_off", fwd_valid, 0);
`endif
    step(); #1;
    check("h_once", load_mem, 0);
    check("h_fwd_pulse", fwd_valid, 0);
    check("h_slot_free", ld_req_ready, 1);

    // lbu hits a buffered sw at byte 2
    step(); commit(mk_st(32'h600, 32'h11223344, 1'b0)); offer(mk_ld(32'h602, 3'b100, 11, 12)); #1;
    step(); #1;
    check("b_stall_load", load_mem, 0);
    check("b_drain", store_wb, 1);
    step(); #1;
`ifdef STORE_FWD_EN
    check("b_fwd_valid", fwd_valid, 1);
    check("b_fwd_data", fwd_data.data, 32'h22);
`else
    check("b_load", load_mem, 1);
    check("b_load_rob", lsq_load.rob_tag, 11);
`endif
    step(); #1;
    check("b_once", load_mem, 0);

    // lbu hits a buffered sh: stall in every build
    step(); commit(mk_st(32'h302, 32'hABCD, 1'b1)); offer(mk_ld(32'h300, 3'b100, 6, 6)); #1;
    step(); #1;
    check("sh_stall", load_mem, 0);
    check("sh_drain", store_wb, 1);
    step(); #1;
    check("sh_load", load_mem, 1);
    check("sh_load_rob", lsq_load.rob_tag, 6);
    check("sh_no_fwd", fwd_valid, 0);

    // flush drops the slot; stores keep draining
    step(); commit(mk_st(32'h800, 32'h8, 1'b0)); offer(mk_ld(32'h700, 3'b010, 7, 7)); #1;
    step(); flush = 1'b1; #1;
    check("fl_no_load", load_mem, 0);
    check("fl_drain", store_wb, 1);
    step(); flush = 1'b1; offer(mk_ld(32'h704, 3'b010, 8, 8)); #1;
    check("fl_ready", ld_req_ready, 1);
    check("fl_no_load2", load_mem, 0);
    step(); #1;
    check("fl_refused", ld_req_ready, 1);
    check("fl_no_load3", load_mem, 0);
    check("fl_empty", sb_empty, 1);

    // two loads around one buffered store
    step(); commit(mk_st(32'h900, 32'h9, 1'b0)); offer(mk_ld(32'h10, 3'b010, 9, 9)); #1;
    step(); #1;
    check("bb_load1", load_mem, 1);
    check("bb_load1_rob", lsq_load.rob_tag, 9);
    check("bb_wb1", store_wb, 0);
    step(); load_ready = 1'b0; offer(mk_ld(32'h20, 3'b010, 10, 10)); #1;
    check("bb_gap_load", load_mem, 0);
    check("bb_gap_wb", store_wb, 1);
    step(); #1;
    check("bb_load2", load_mem, 1);
    check("bb_load2_rob", lsq_load.rob_tag, 10);
    check("bb_excl", 32'(load_mem & store_wb), 0);

    // asynchronous reset mid-operation
    step(); commit(mk_st(32'hA00, 32'hA, 1'b0)); offer(mk_ld(32'hB00, 3'b010, 12, 12)); #1;
    step(); #1;
    check("mr_count_pre", sb_count, 1);
    reset = 1'b0; #1;
    check("mr_count", sb_count, 0);
    check("mr_slot", ld_req_ready, 1);
    check("mr_wb", store_wb, 0);
    check("mr_load", load_mem, 0);
    step(); reset = 1'b1; #1;
    check("mr_empty", sb_empty, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_req_scheduler.md
# mem_req_scheduler

- Sits directly upstream of the data memory.
- Buffers committed stores in a small FIFO and holds one pending load.
- Each cycle it issues at most one memory operation: a load (`load_mem`) or a store drain (`store_wb`), never both.
- Blocks a load that reads a word still held in the store buffer; can optionally forward store data to that load.

## Interface
- `SB_DEPTH`, 4, store-buffer entries (power of two, ≥2)
- `WADDR_BITS`, 15, word-address compare width (`addr[WADDR_BITS+1:2]`)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `st_commit_valid`  in  1  ROB commits a store this cycle
- `st_commit_entry`  in  lsq  committed store (addr, ps2_data, sw_sh_signal, store=1)
- `st_commit_ready`  out  1  buffer can accept a commit
- `ld_req_valid`  in  1  LSQ presents a load
- `ld_req`  in  lsq  load (addr, func3, rob_tag, pd, store=0)
- `ld_req_ready`  out  1  load slot empty
- `flush`  in  1  mispredict flush; drops the pending load only
- `load_ready`  in  1  memory can accept a load
- `store_wb`  out  1  store write to memory this cycle
- `lsq_in`  out  lsq  store-buffer head entry
- `load_mem`  out  1  load request to memory this cycle
- `lsq_load`  out  lsq  load slot contents
- `fwd_valid`  out  1  forwarded load result (only with `STORE_FWD_EN`)
- `fwd_data`  out  mem_data  forwarded result: data, rob_fu_mem, p_mem, fu_mem_ready/done=1
- `sb_count`  out  $clog2(SB_DEPTH)+1  occupied entries
- `sb_empty`  out  1  `sb_count==0`

## Operation
**Store buffer**
- Circular FIFO with head, tail and count registers.
- Push when `st_commit_valid && st_commit_ready && st_commit_entry.store`.
- Commits with `store=0` are discarded.
- `st_commit_ready = (count != SB_DEPTH)`, computed from the registered count. A full buffer refuses a commit even in a cycle where it drains.

**Load slot**
- One register plus a valid bit. `ld_req_ready = !slot_valid`.
- Accepted on `ld_req_valid && ld_req_ready && !flush && !ld_req.store`.
- `flush` clears the slot at the next edge; a request offered in the flush cycle is not accepted.

**Hazard**
- The slot conflicts when any valid SB entry has the same `addr[WADDR_BITS+1:2]` as the load.

**Issue arbitration**
- Combinational from registered state and `load_ready`, in this priority order:
  1. `count==SB_DEPTH` → drain.
  2. `slot_valid && !hazard && load_ready` → issue the load.
  3. `count!=0` → drain.
  4. Otherwise idle.
- Drain: `store_wb=1`, `lsq_in=head`; head pops at the same edge.
- Issue: `load_mem=1`, `lsq_load=slot`; the slot clears at the same edge.
- `lsq_in` and `lsq_load` are driven `'0` when the matching strobe is low.
- A push and a pop in the same cycle leave the count unchanged.
- Each load issues exactly once.
- Memory returns `load_ready=0` in the cycle after accepting a load, so back-to-back loads are impossible. A store may drain in that gap.

**Forwarding**
- Under `STORE_FWD_EN` the hazard case is resolved as described in Configuration. Otherwise the load waits for the drain.

## Timing
- Reset (asynchronous, `reset=0`):
  - count, head, tail, `slot_valid`, `fwd_valid` and `fwd_data` cleared.
  - Outputs: `store_wb=0`, `load_mem=0`, `st_commit_ready=1`, `ld_req_ready=1`, `sb_empty=1`, `sb_count=0`.
- Load path:
  - A load accepted at edge N is issuable in cycle N+1 at the earliest.
  - The memory result appears two cycles after the issue cycle.
- Store path: a commit at edge N can drain in cycle N+1 at the earliest.
- Forward latency: `fwd_valid` is asserted for one cycle, in the cycle after the slot is resolved.
- Reset asserted mid-operation drops buffered stores and the load; the ROB recovers from this.

## Configuration
- `STORE_FWD_EN` defined:
  - If the youngest matching SB entry is an `sw` (`sw_sh_signal=0`), the slot is cleared at the edge.
  - `fwd_valid=1` in the next cycle. `fwd_data.data = ps2_data` for `func3=010`; for `func3=100` it is `{24'b0, byte addr[1:0]}`.
  - `fwd_data.rob_fu_mem` and `fwd_data.p_mem` take the load's `rob_tag` and `pd`.
  - A match against `sh` stalls as usual.
  - Forwarding never consumes a memory cycle.
- `STORE_FWD_EN` undefined: `fwd_valid=0` and `fwd_data='0` permanently; every hazard stalls.

## Test plan
- Reset, then commit `sw` to 0x100 with data 0xDEADBEEF → `store_wb=1` in the next cycle with `lsq_in.addr=0x100`; `sb_empty=1` afterwards.
- Commit 4 stores with no drain possible → `st_commit_ready=0`. A fifth commit is refused; drain then takes priority over a waiting non-conflicting load.
- `sw` 0x200 buffered, then `lw` 0x200 (rob 5):
  - Without the macro: `load_mem` is held low until the store drains, then `load_mem=1` with rob_tag 5.
  - With the macro: `fwd_valid=1` with data 0xDEADBEEF and `rob_fu_mem=5`; `load_mem` never asserts.
- `sh` 0x302 buffered, `lbu` 0x300 → stall in both builds until the `sh` drains.
- Load accepted, `flush` asserted the next cycle → no `load_mem`, `ld_req_ready=1`; buffered stores still drain.
- Loads to 0x10 and then 0x20 back-to-back with one store buffered → `load_mem` and `store_wb` never high together, and loads are at least 2 cycles apart.
